// File: rtl/pin_debouncer_pkg.sv
// Shared types and constants for the pin debouncer: per-channel FSM state
// encoding, counter width and the lower bound on the stability window.
package pin_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b10,
    CHK_LO    = 2'b11
  } db_state_e;

  localparam int unsigned CNT_W             = 16;
  localparam int unsigned STABLE_CYCLES_MIN = 2;

endpackage

// File: rtl/pin_debouncer_if.sv
// Pin-side and interrupt-side signals of the debouncer, grouped as one bundle.
interface pin_debouncer_if #(
  parameter int unsigned WIDTH = 2
);
  logic [WIDTH-1:0] io_pins_raw;
  logic [WIDTH-1:0] io_pins_clean;
  logic [WIDTH-1:0] io_rise;
  logic [WIDTH-1:0] io_fall;
  logic [WIDTH-1:0] io_riseEnable;
  logic [WIDTH-1:0] io_fallEnable;
  logic [WIDTH-1:0] io_irqClear;
  logic [WIDTH-1:0] io_irqPending;
  logic             io_irq;

  modport master (
    output io_pins_raw, io_riseEnable, io_fallEnable, io_irqClear,
    input  io_pins_clean, io_rise, io_fall, io_irqPending, io_irq
  );

  modport slave (
    input  io_pins_raw, io_riseEnable, io_fallEnable, io_irqClear,
    output io_pins_clean, io_rise, io_fall, io_irqPending, io_irq
  );
endinterface

// File: rtl/pin_debouncer_channel.sv
// One debounced input: two-flop synchronizer, accept/reject FSM with a
// saturating stability counter, one-cycle edge pulses and a sticky IRQ flag.
module debounce_channel
  import pin_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic clr_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic pend_o
);

  localparam int unsigned WINDOW =
    (STABLE_CYCLES < STABLE_CYCLES_MIN) ? STABLE_CYCLES_MIN : STABLE_CYCLES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  localparam db_state_e RESET_STATE = RESET_BIT ? STABLE_HI : STABLE_LO;

  logic           sync1_q, sync2_q;
  db_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic           clean_q, rise_q, fall_q;
  logic           pend_q, pend_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RESET_BIT;
      sync2_q <= RESET_BIT;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // clean and the edge pulses are registered alongside the state so the
  // pulse lands on the same edge as the clean transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      clean_q <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (sync2_q) begin
            state_q <= CHK_HI;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_HI: begin
          if (!sync2_q) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!sync2_q) begin
            state_q <= CHK_LO;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        CHK_LO: begin
          if (sync2_q) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RESET_STATE;
          cnt_q   <= '0;
          clean_q <= RESET_BIT;
        end
      endcase
    end
  end

  // A new qualifying edge outranks a clear arriving on the same cycle.
  always_comb begin
    pend_d = (rise_q & rise_en_i) | (fall_q & fall_en_i) | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= 1'b0;
    else         pend_q <= pend_d;
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/pin_debouncer.sv
// Multi-channel pin debouncer: WIDTH independent debounce channels plus a
// combined interrupt line.
module pin_debouncer
  import pin_debouncer_pkg::*;
#(
  parameter int unsigned      WIDTH         = 2,
  parameter int unsigned      STABLE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = '0
) (
  input  logic             io_mainClk,
  input  logic             io_asyncResetn,
  pin_debouncer_if.slave   bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_LEVEL[i])
    ) u_ch (
      .clk_i     (io_mainClk),
      .rst_ni    (io_asyncResetn),
      .raw_i     (bus.io_pins_raw[i]),
      .rise_en_i (bus.io_riseEnable[i]),
      .fall_en_i (bus.io_fallEnable[i]),
      .clr_i     (bus.io_irqClear[i]),
      .clean_o   (bus.io_pins_clean[i]),
      .rise_o    (bus.io_rise[i]),
      .fall_o    (bus.io_fall[i]),
      .pend_o    (bus.io_irqPending[i])
    );
  end

  assign bus.io_irq = |bus.io_irqPending;

endmodule
